evp_operand_store: RTL and testbench
====================================

// Module: evp_operand_store
// PURPOSE
//  Memory-side responder for the EVP evaluator's read interface. The host loads it with
//  coefficients S, per-slot degrees N and x operands. It answers en_rd_S/en_rd_N/en_rd_data
//  requests with registered data (c_i, N, x). It owns the data read pointer and takes the
//  EVP's updated pointer when done_evp pulses.
// PARAMETERS
//  word_size      16    width of coefficients and x operands
//  buffer_size    1024  depth of circular x-operand buffer (power of two)
//  coeff_per_slot 11    coefficients per instruction slot A (maximum degree 10)
//  n_slots        8     number of slots; S depth = n_slots*coeff_per_slot = 88
// PORTS
//  clk                  in   1          system clock
//  rst                  in   1          async active-low reset
//  wr_en_S              in   1          host write strobe for S
//  wr_addr_S            in   7          S address (A*11+k)
//  wr_data_S            in   word_size  coefficient value
//  wr_en_N              in   1          host write strobe for N
//  wr_addr_N            in   3          slot A
//  wr_data_N            in   5          degree of the slot
//  push_data            in   1          push din_data into the x buffer
//  din_data             in   word_size  x operand
//  en_rd_S              in   1          EVP coefficient read request
//  rd_addr_S            in   7          coefficient address
//  en_rd_N              in   1          EVP degree read request
//  rd_addr_N            in   3          slot address
//  en_rd_data           in   1          EVP x read request (reads at rd_addr_data)
//  rd_addr_data_updated in   log2(bs)   EVP's next read pointer
//  done_evp             in   1          commit strobe for rd_addr_data_updated
//  clr_status           in   1          clear sticky status bits
//  c_i                  out  word_size  coefficient response
//  N                    out  5          degree response
//  x                    out  word_size  x response
//  rd_addr_data         out  log2(bs)   current x read pointer
//  data_count           out  log2(bs)+1 words held in the x buffer
//  data_full            out  1          data_count == buffer_size
//  data_empty           out  1          data_count == 0
//  status               out  4          {underflow, overflow, n_err, s_err}, sticky
// BEHAVIOUR
//  Reset (rst==0, async): c_i=0, N=0, x=0, rd_addr_data=0, write pointer=0, data_count=0,
//   data_empty=1, data_full=0, status=0. Memory contents are undefined. Reset mid-operation
//   aborts everything and drops any pending commit.
//  Read latency is 1 cycle. en_rd_* sampled at edge t gives the output valid after edge t
//   and held until the next accepted request for that port. S, N and x ports are independent.
//   Simultaneous requests on all three are served in the same cycle.
//  Read and write to the same S/N address in one cycle: the read returns the OLD value
//   (read-before-write). The write lands.
//  S write with wr_addr_S >= 88: ignored, s_err<=1. EVP read with rd_addr_S >= 88: c_i<=0, s_err<=1.
//  N write with wr_data_N > 10: ignored, n_err<=1.
//  x buffer is circular, modulo buffer_size.
//   - push while not full: mem[wp]<=din, wp<=wp+1, count+1.
//   - push while full: dropped, overflow<=1.
//  en_rd_data while data_empty: x holds its value, underflow<=1. Otherwise x<=mem[rd_addr_data].
//   A read alone does not move the pointer.
//  done_evp: consumed=(rd_addr_data_updated-rd_addr_data) mod buffer_size.
//   - consumed <= count: rd_addr_data<=updated, count-=consumed.
//   - consumed > count: underflow<=1, rd_addr_data<=wp, count<=0.
//  Push and done_evp in the same cycle: count_next = count + push_accepted - consumed.
//   Full is judged on the pre-commit count.
//  Status: bits set per the rules above, all sticky. clr_status clears them.
//   A set and a clear in the same cycle leaves the bit set.
//  State machine on the x buffer, encoded from data_count:
//   EMPTY -(push)-> ACTIVE; ACTIVE -(count reaches buffer_size)-> FULL;
//   ACTIVE/FULL -(commit to 0)-> EMPTY; FULL -(commit>0)-> ACTIVE.
// TESTING
//  1. S[0..3]=3,4,2,1; N[0]=3; push 2,1,4. Then en_rd_N addr0 -> N=3 next cycle;
//     en_rd_S addr 0..3 -> c_i=3,4,2,1; en_rd_data -> x=2.
//  2. done_evp, updated=1 -> rd_addr_data=1, data_count=2; en_rd_data -> x=1.
//  3. Push 1024 words, then push 1 more -> data_full=1, status[2]=1, count stays 1024;
//     wp wraps to 0.
//  4. Same-cycle wr_en_S/en_rd_S addr 5 (old 7, new 9) -> c_i=7, then a later read -> 9.
//  5. wr_addr_S=90 -> s_err=1; wr_data_N=12 -> n_err=1; clr_status -> status=0.
//  6. Empty buffer: en_rd_data -> underflow=1, x unchanged. rst low mid-load -> all outputs
//     at their reset values immediately.

Source files
------------

// File: rtl/evp_operand_store.sv
// Memory-side responder for the EVP evaluator: holds coefficients S, slot degrees N and
// a circular buffer of x operands, and answers the EVP's registered read requests.
module evp_operand_store #(
    parameter int word_size      = 16,
    parameter int buffer_size    = 1024,
    parameter int coeff_per_slot = 11,
    parameter int n_slots        = 8,
    localparam int aw            = $clog2(buffer_size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_S,
    input  logic [6:0]           wr_addr_S,
    input  logic [word_size-1:0] wr_data_S,
    input  logic                 wr_en_N,
    input  logic [2:0]           wr_addr_N,
    input  logic [4:0]           wr_data_N,
    input  logic                 push_data,
    input  logic [word_size-1:0] din_data,
    input  logic                 en_rd_S,
    input  logic [6:0]           rd_addr_S,
    input  logic                 en_rd_N,
    input  logic [2:0]           rd_addr_N,
    input  logic                 en_rd_data,
    input  logic [aw-1:0]        rd_addr_data_updated,
    input  logic                 done_evp,
    input  logic                 clr_status,
    output logic [word_size-1:0] c_i,
    output logic [4:0]           N,
    output logic [word_size-1:0] x,
    output logic [aw-1:0]        rd_addr_data,
    output logic [aw:0]          data_count,
    output logic                 data_full,
    output logic                 data_empty,
    output logic [3:0]           status,
    output logic [1:0]           buf_state
);

    localparam int s_depth = n_slots * coeff_per_slot;
    localparam logic [6:0]  s_limit    = 7'(s_depth);
    localparam logic [4:0]  max_deg    = 5'(coeff_per_slot - 1);
    localparam logic [aw:0] full_count = (aw + 1)'(buffer_size);

    localparam logic [1:0] st_empty  = 2'd0;
    localparam logic [1:0] st_active = 2'd1;
    localparam logic [1:0] st_full   = 2'd2;

    // Request handshake: en_rd_* are single-cycle strobes with no ready; every request is
    // accepted at the edge that samples it, and its response is registered, valid after that
    // edge and held until the next accepted request on the same port.

    logic [word_size-1:0] s_mem [0:s_depth-1];
    logic [4:0]           n_mem [0:n_slots-1];
    logic [word_size-1:0] x_mem [0:buffer_size-1];

    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr_next;
    logic [aw-1:0] consumed;
    logic [aw:0]   count_base;
    logic [aw:0]   count_next;
    logic          push_acc;
    logic          over_commit;
    logic          s_wr_ok;
    logic          s_rd_ok;
    logic          n_wr_ok;
    logic [3:0]    status_set;
    logic [3:0]    status_next;

    assign data_full  = (data_count == full_count);
    assign data_empty = (data_count == '0);

    always_comb begin
        if (data_empty)     buf_state = st_empty;
        else if (data_full) buf_state = st_full;
        else                buf_state = st_active;
    end

    always_comb begin
        push_acc    = push_data && !data_full;
        consumed    = rd_addr_data_updated - rd_addr_data;
        over_commit = done_evp && ({1'b0, consumed} > data_count);
        rd_ptr_next = rd_addr_data;
        count_base  = data_count;
        if (done_evp) begin
            if (over_commit) begin
                // Commit beyond the held data: discard everything and resync to the writer.
                rd_ptr_next = wr_ptr;
                count_base  = '0;
            end else begin
                rd_ptr_next = rd_addr_data_updated;
                count_base  = data_count - {1'b0, consumed};
            end
        end
        count_next = count_base + {{aw{1'b0}}, push_acc};
    end

    always_comb begin
        s_wr_ok       = wr_addr_S < s_limit;
        s_rd_ok       = rd_addr_S < s_limit;
        n_wr_ok       = wr_data_N <= max_deg;
        status_set    = '0;
        status_set[0] = (wr_en_S && !s_wr_ok) || (en_rd_S && !s_rd_ok);
        status_set[1] = wr_en_N && !n_wr_ok;
        status_set[2] = push_data && data_full;
        status_set[3] = over_commit || (en_rd_data && data_empty);
        status_next   = (status & ~{4{clr_status}}) | status_set;
    end

    // Storage arrays carry no reset; their contents are undefined until loaded.
    always_ff @(posedge clk) begin
        if (wr_en_S && s_wr_ok) s_mem[wr_addr_S] <= wr_data_S;
        if (wr_en_N && n_wr_ok) n_mem[wr_addr_N] <= wr_data_N;
        if (push_acc)           x_mem[wr_ptr]    <= din_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_i          <= '0;
            N            <= '0;
            x            <= '0;
            rd_addr_data <= '0;
            wr_ptr       <= '0;
            data_count   <= '0;
            status       <= '0;
        end else begin
            if (en_rd_S) c_i <= s_rd_ok ? s_mem[rd_addr_S] : '0;
            if (en_rd_N) N <= n_mem[rd_addr_N];
            if (en_rd_data && !data_empty) x <= x_mem[rd_addr_data];
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            rd_addr_data <= rd_ptr_next;
            data_count   <= count_next;
            status       <= status_next;
        end
    end

endmodule

// File: tb/tb_evp_operand_store.sv
// Directed bench for evp_operand_store: a queue model of the x buffer plus S/N shadow
// arrays supply every expected value; expected read responses wait in per-port queues.
module tb_evp_operand_store;

    localparam int bs = 1024;
    localparam logic [1:0] st_empty  = 2'd0;
    localparam logic [1:0] st_active = 2'd1;
    localparam logic [1:0] st_full   = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en_S = 0, wr_en_N = 0, push_data = 0, en_rd_S = 0, en_rd_N = 0;
    logic        en_rd_data = 0, done_evp = 0, clr_status = 0;
    logic [6:0]  wr_addr_S = 0, rd_addr_S = 0;
    logic [2:0]  wr_addr_N = 0, rd_addr_N = 0;
    logic [4:0]  wr_data_N = 0;
    logic [15:0] wr_data_S = 0, din_data = 0;
    logic [9:0]  rd_addr_data_updated = 0;
    logic [15:0] c_i, x;
    logic [4:0]  N;
    logic [9:0]  rd_addr_data;
    logic [10:0] data_count;
    logic        data_full, data_empty;
    logic [3:0]  status;
    logic [1:0]  buf_state;

    evp_operand_store dut (
        .clk(clk), .rst(rst),
        .wr_en_S(wr_en_S), .wr_addr_S(wr_addr_S), .wr_data_S(wr_data_S),
        .wr_en_N(wr_en_N), .wr_addr_N(wr_addr_N), .wr_data_N(wr_data_N),
        .push_data(push_data), .din_data(din_data),
        .en_rd_S(en_rd_S), .rd_addr_S(rd_addr_S),
        .en_rd_N(en_rd_N), .rd_addr_N(rd_addr_N),
        .en_rd_data(en_rd_data), .rd_addr_data_updated(rd_addr_data_updated),
        .done_evp(done_evp), .clr_status(clr_status),
        .c_i(c_i), .N(N), .x(x), .rd_addr_data(rd_addr_data), .data_count(data_count),
        .data_full(data_full), .data_empty(data_empty), .status(status), .buf_state(buf_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] c_exp_q[$];
    logic [15:0] n_exp_q[$];
    logic [15:0] x_exp_q[$];
    logic [15:0] s_model [0:87];
    logic [4:0]  n_model [0:7];
    logic [15:0] xq[$];
    logic [15:0] last_x = 0;
    logic [3:0]  status_m = 0;
    int          rp_m = 0;
    int          wp_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr_s(input logic [6:0] a, input logic [15:0] d, input bit clr);
        wr_en_S = 1; wr_addr_S = a; wr_data_S = d; clr_status = clr;
        if (clr) status_m = 0;
        if (a < 88) s_model[a] = d;
        else status_m[0] = 1;
        tick();
        wr_en_S = 0; clr_status = 0;
    endtask

    task automatic wr_n(input logic [2:0] a, input logic [4:0] d);
        wr_en_N = 1; wr_addr_N = a; wr_data_N = d;
        if (d <= 10) n_model[a] = d;
        else status_m[1] = 1;
        tick();
        wr_en_N = 0;
    endtask

    task automatic rd_s(input logic [6:0] a);
        en_rd_S = 1; rd_addr_S = a;
        if (a < 88) c_exp_q.push_back(s_model[a]);
        else begin c_exp_q.push_back(16'h0); status_m[0] = 1; end
        tick();
        en_rd_S = 0;
        chk("c_i", c_i, c_exp_q.pop_front());
    endtask

    task automatic rd_n(input logic [2:0] a);
        en_rd_N = 1; rd_addr_N = a;
        n_exp_q.push_back(16'(n_model[a]));
        tick();
        en_rd_N = 0;
        chk("N", N, n_exp_q.pop_front());
    endtask

    task automatic rd_x();
        en_rd_data = 1;
        if (xq.size() == 0) status_m[3] = 1;
        else last_x = xq[0];
        x_exp_q.push_back(last_x);
        tick();
        en_rd_data = 0;
        chk("x", x, x_exp_q.pop_front());
    endtask

    task automatic x_step(input bit push, input logic [15:0] d, input bit commit, input int k);
        int pre;
        bit acc;
        logic [15:0] dummy;
        pre = xq.size();
        acc = push && (pre < bs);
        push_data = push; din_data = d; done_evp = commit;
        rd_addr_data_updated = 10'((rp_m + k) % bs);
        if (push && !acc) status_m[2] = 1;
        if (commit) begin
            if (k <= pre) begin
                for (int i = 0; i < k; i++) dummy = xq.pop_front();
                rp_m = (rp_m + k) % bs;
            end else begin
                xq.delete();
                rp_m = wp_m;
                status_m[3] = 1;
            end
        end
        if (acc) begin
            xq.push_back(d);
            wp_m = (wp_m + 1) % bs;
        end
        tick();
        push_data = 0; done_evp = 0;
    endtask

    task automatic chk_buf(input string tag);
        chk({tag, ".count"}, data_count, xq.size());
        chk({tag, ".rd_addr"}, rd_addr_data, rp_m);
        chk({tag, ".empty"}, data_empty, xq.size() == 0);
        chk({tag, ".full"}, data_full, xq.size() == bs);
        chk({tag, ".state"}, buf_state,
            xq.size() == 0 ? st_empty : (xq.size() == bs ? st_full : st_active));
        chk({tag, ".status"}, status, status_m);
    endtask

    task automatic clr();
        clr_status = 1;
        tick();
        clr_status = 0;
        status_m = 0;
        chk("clr.status", status, status_m);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".c_i"}, c_i, 0);
        chk({tag, ".N"}, N, 0);
        chk({tag, ".x"}, x, 0);
        chk({tag, ".rd_addr"}, rd_addr_data, 0);
        chk({tag, ".count"}, data_count, 0);
        chk({tag, ".empty"}, data_empty, 1);
        chk({tag, ".full"}, data_full, 0);
        chk({tag, ".status"}, status, 0);
    endtask

    initial begin
        rst = 1;
        #2 rst = 0;
        #1 chk_reset("reset");
        tick(); tick();
        rst = 1;
        tick();

        // Load and basic reads
        wr_s(0, 3, 0); wr_s(1, 4, 0); wr_s(2, 2, 0); wr_s(3, 1, 0);
        wr_n(0, 3);
        x_step(1, 2, 0, 0); x_step(1, 1, 0, 0); x_step(1, 4, 0, 0);
        chk_buf("load");
        rd_n(0);
        for (int a = 0; a < 4; a++) rd_s(7'(a));
        rd_x();
        tick();
        chk("x.hold", x, last_x);

        // All three ports in one cycle
        en_rd_S = 1; rd_addr_S = 2; en_rd_N = 1; rd_addr_N = 0; en_rd_data = 1;
        c_exp_q.push_back(s_model[2]); n_exp_q.push_back(16'(n_model[0]));
        last_x = xq[0]; x_exp_q.push_back(last_x);
        tick();
        en_rd_S = 0; en_rd_N = 0; en_rd_data = 0;
        chk("sim.c_i", c_i, c_exp_q.pop_front());
        chk("sim.N", N, n_exp_q.pop_front());
        chk("sim.x", x, x_exp_q.pop_front());

        // Commit, then an over-commit
        x_step(0, 0, 1, 1);
        chk_buf("commit1");
        rd_x();
        x_step(0, 0, 1, 5);
        chk_buf("overcommit");
        clr();

        // Fill, overflow, and push/commit in one cycle
        for (int i = 0; i < bs; i++) x_step(1, 16'($urandom_range(0, 65535)), 0, 0);
        chk_buf("fill");
        x_step(1, 16'hDEAD, 0, 0);
        chk_buf("overflow");
        clr();
        x_step(1, 16'hBEEF, 1, 1000);
        chk_buf("full_push_commit");
        rd_x();
        x_step(1, 16'h1234, 1, 10);
        chk_buf("push_commit");
        rd_x();
        x_step(0, 0, 1, xq.size());
        chk_buf("drain");
        clr();

        // Read-before-write on S, out-of-range S read
        wr_s(5, 7, 0);
        wr_en_S = 1; wr_addr_S = 5; wr_data_S = 9; en_rd_S = 1; rd_addr_S = 5;
        c_exp_q.push_back(s_model[5]);
        s_model[5] = 9;
        tick();
        wr_en_S = 0; en_rd_S = 0;
        chk("rbw.old", c_i, c_exp_q.pop_front());
        rd_s(5);
        rd_s(100);
        chk("rd_oob.status", status, status_m);
        clr();

        // Error strobes and set-beats-clear
        wr_s(90, 16'hAAAA, 0);
        chk("s_err", status, status_m);
        wr_n(1, 5);
        wr_n(1, 12);
        chk("n_err", status, status_m);
        rd_n(1);
        clr();
        wr_s(95, 16'h5555, 1);
        chk("set_over_clr", status, status_m);
        clr();

        // Underflow on empty read, then reset in the middle of loading
        rd_x();
        chk("underflow.status", status, status_m);
        rd_s(1);
        rd_n(0);
        x_step(1, 16'h0042, 0, 0);
        wr_en_S = 1; wr_addr_S = 6; wr_data_S = 16'h0077; push_data = 1; din_data = 16'h0099;
        #2 rst = 0;
        #1 chk_reset("mid_reset");
        wr_en_S = 0; push_data = 0;
        tick();
        rst = 1;
        xq.delete(); rp_m = 0; wp_m = 0; status_m = 0; last_x = 0;
        tick();
        x_step(1, 16'h0055, 0, 0);
        chk_buf("post_reset");
        rd_x();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
